// File: rtl/ifetch_queue.sv
// ifetch_queue: 8-halfword queue turning I$ words into 16/32-bit decode instructions; IFETCH_QUEUE_BYPASS_EN adds an empty-queue bypass.
// Latency: ACK to IR_VALID one CE cycle (same cycle with the bypass when the queue is empty).
// Backpressure: one fetch in flight; no new fetch while more than 6 halfwords would remain queued.
module ifetch_queue (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic        FLUSH,
  input  logic [30:0] FLUSH_PC,
  output logic        IC_REQ,
  output logic [29:0] IC_A,
  input  logic        IC_ACK,
  input  logic [31:0] IC_D,
  output logic        IR_VALID,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_LEN32,
  input  logic        ID_TAKE
);

  logic [15:0] q [8];
  logic [2:0]  rd_ptr;
  logic [3:0]  count;
  logic [31:0] ir_pc;
  logic [29:0] ic_a;
  logic [29:0] redir_a;
  logic        ic_req;
  logic        discard;
  logic        odd_first;

  logic        ack_any;
  logic        ack_ok;
  logic [15:0] a0, a1;
  logic [1:0]  n_avail;
  logic        byp;
  logic [15:0] h0, h1;
  logic [3:0]  cnt_eff;
  logic        len32;
  logic        ir_vld;
  logic        take;
  logic [1:0]  taken;
  logic [1:0]  pop;
  logic [1:0]  enq_n;
  logic [15:0] e0, e1;
  logic [2:0]  tail;
  logic [3:0]  count_after;
  logic        eligible;

  always_comb begin
    ack_any = CE && ic_req && IC_ACK;
    ack_ok  = ack_any && !discard && !FLUSH;
    // After an odd-halfword redirect only the upper halfword of the word is wanted.
    a0      = odd_first ? IC_D[31:16] : IC_D[15:0];
    a1      = IC_D[31:16];
    n_avail = odd_first ? 2'd1 : 2'd2;
`ifdef IFETCH_QUEUE_BYPASS_EN
    byp     = ack_ok && (count == 4'd0);
`else
    byp     = 1'b0;
`endif
    if (byp) begin
      h0      = a0;
      h1      = a1;
      cnt_eff = {2'b00, n_avail};
    end else begin
      h0      = q[rd_ptr];
      h1      = q[rd_ptr + 3'd1];
      cnt_eff = count;
    end
    len32  = (h0[15:10] >= 6'h28);
    ir_vld = (cnt_eff >= 4'd2) || ((cnt_eff == 4'd1) && !len32);
    take   = CE && ID_TAKE && ir_vld && !FLUSH;
    taken  = take ? (len32 ? 2'd2 : 2'd1) : 2'd0;
    pop    = byp ? 2'd0 : taken;

    enq_n = 2'd0;
    e0    = a0;
    e1    = a1;
    if (ack_ok) begin
      if (byp && take) begin
        // Halfwords consumed straight from IC_D never enter the queue.
        enq_n = n_avail - taken;
        e0    = a1;
      end else begin
        enq_n = n_avail;
      end
    end

    tail        = rd_ptr + count[2:0];
    count_after = count + {2'b00, enq_n} - {2'b00, pop};
    eligible    = (count_after <= 4'd6);
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      rd_ptr    <= 3'd0;
      count     <= 4'd0;
      ir_pc     <= 32'hFFFF_FFF0;
      ic_a      <= 30'h3FFF_FFFC;
      redir_a   <= 30'd0;
      ic_req    <= 1'b0;
      discard   <= 1'b0;
      odd_first <= 1'b0;
    end else if (CE) begin
      if (FLUSH) begin
        count     <= 4'd0;
        ir_pc     <= {FLUSH_PC, 1'b0};
        odd_first <= FLUSH_PC[0];
        if (ic_req && !IC_ACK) begin
          // The I$ cannot cancel a request: keep it up and drop its data later.
          discard <= 1'b1;
          redir_a <= FLUSH_PC[30:1];
        end else begin
          discard <= 1'b0;
          ic_a    <= FLUSH_PC[30:1];
          ic_req  <= 1'b1;
        end
      end else begin
        rd_ptr <= rd_ptr + {1'b0, pop};
        count  <= count_after;
        ir_pc  <= ir_pc + {29'd0, taken, 1'b0};
        if (ack_ok) begin
          odd_first <= 1'b0;
          ic_a      <= ic_a + 30'd1;
          ic_req    <= eligible;
        end else if (ack_any) begin
          discard <= 1'b0;
          ic_a    <= redir_a;
          ic_req  <= 1'b1;
        end else if (!ic_req) begin
          ic_req <= eligible;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES && ack_ok) begin
      if (enq_n != 2'd0) q[tail] <= e0;
      if (enq_n == 2'd2) q[tail + 3'd1] <= e1;
    end
  end

  assign IC_REQ   = ic_req;
  assign IC_A     = ic_a;
  assign IR_VALID = ir_vld;
  assign IR       = len32 ? {h1, h0} : {16'h0000, h0};
  assign IR_LEN32 = len32;
  assign IR_PC    = ir_pc;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- CLK  in  1  system clock; all state updates on its rising edge.
- RES  in  1  synchronous, active-high reset.
- CE  in  1  clock enable; state advances only on CLK edges where CE=1.
- FLUSH  in  1  redirect request from execute (branch, trap, reset vector).
- FLUSH_PC  in  31  redirect target, halfword address [31:1].
- IC_REQ  out  1  word fetch request to the I$.
- IC_A  out  30  fetch word address [31:2].
- IC_ACK  in  1  I$ fetch complete; IC_D is valid in the same cycle.
- IC_D  in  32  fetched word; the low halfword is at the lower address.
- IR_VALID  out  1  a complete instruction is presented to decode.
- IR  out  32  [15:0] is the first halfword and [31:16] is the second halfword (zero for 16-bit instructions).
- IR_PC  out  32  address of the presented instruction, with bit 0 = 0.
- IR_LEN32  out  1  the presented instruction is 32 bits long.
- ID_TAKE  in  1  decode consumes the presented instruction.

REQ-002 The clock port SHALL be CLK and the reset port SHALL be RES; there is one clock, and the reset is synchronous and active-high.

Function
REQ-003 The queue SHALL hold 8 halfword entries in a circular buffer, with a 3-bit read pointer that wraps from 7 to 0 and a 4-bit count in the range 0..8.
REQ-004 Instruction length SHALL be decided from the first halfword: if bits [15:10] >= 6'h28, the instruction is 32-bit; otherwise it is 16-bit.
REQ-005 IR_VALID SHALL be 1 when count >= 2, or when count = 1 and the head halfword is a 16-bit instruction; otherwise it SHALL be 0.
REQ-006 ID_TAKE while IR_VALID=1 SHALL remove 1 halfword (16-bit) or 2 halfwords (32-bit) and advance IR_PC by 2 or 4, modulo 2^32. ID_TAKE while IR_VALID=0 SHALL be ignored.
REQ-007 At most one fetch SHALL be outstanding at a time. A new fetch SHALL be issued only when count, minus halfwords taken this cycle, is <= 6 and no fetch is in flight.
REQ-008 Once IC_REQ is asserted, IC_REQ and IC_A SHALL be held stable until a CE cycle with IC_ACK=1. IC_REQ SHALL drop in the cycle after the ACK unless the next request is eligible, in which case it stays high with IC_A+1.
REQ-009 On an ACK, both halfwords SHALL be enqueued at the tail, except in the first fetch after a redirect with FLUSH_PC[1]=1, where only IC_D[31:16] is enqueued.
REQ-010 IC_A SHALL increment by 1 per accepted fetch, wrapping from 30'h3FFFFFFF to 0.
REQ-011 Simultaneous enqueue and take in one CE cycle SHALL both take effect: count_next = count + enqueued - taken.
REQ-012 FLUSH SHALL have priority over all other events. In that cycle: count <= 0; IR_PC <= {FLUSH_PC, 1'b0}; fetch address <= FLUSH_PC[31:2]; ID_TAKE and any same-cycle ACK data are discarded.
REQ-013 If a fetch is in flight when FLUSH occurs, the request SHALL NOT be withdrawn. IC_REQ and the old IC_A SHALL be held until the ACK, that data SHALL be discarded, and the redirected fetch SHALL be issued the following CE cycle.
REQ-014 A second FLUSH while a discard is pending SHALL replace the redirect target, and only one discard SHALL occur.
REQ-015 IR, IR_LEN32 and IR_VALID SHALL be combinational from the queue head, except as modified by REQ-020.

Reset
REQ-016 While RES=1 at a CE edge, the block SHALL set: IC_REQ=0, count=0, IR_VALID=0, IR_PC=32'hFFFFFFF0, fetch address=30'h3FFFFFFC, and clear the discard flag.
REQ-017 The first fetch SHALL be issued in the first CE cycle after RES falls.
REQ-018 RES asserted while a fetch is in flight SHALL drop IC_REQ immediately; the next ACK after reset SHALL be treated as belonging to the new request only.

Configuration
REQ-019 The macro IFETCH_QUEUE_BYPASS_EN SHALL select bypass behaviour.
REQ-020 With IFETCH_QUEUE_BYPASS_EN defined: when count=0 and an ACK arrives, IR/IR_VALID/IR_LEN32 SHALL be driven from IC_D in the same cycle if it holds a complete instruction. If ID_TAKE also asserts, the consumed halfwords SHALL NOT be enqueued.
REQ-021 With IFETCH_QUEUE_BYPASS_EN undefined: IR_VALID SHALL rise no earlier than one CE cycle after the ACK.

Verification
REQ-022 Reset, with I$ acking each request after 1 CE cycle -> first IC_A=30'h3FFFFFFC; IR_PC=FFFFFFF0 when IR_VALID first rises.
REQ-023 Word 0x9A00445F with ID_TAKE held high -> two 16-bit instructions presented: IR=445F at PC n, then IR=9A00 at PC n+2.
REQ-024 Word A8000404 fetched at odd-halfword redirect FLUSH_PC=0x4000000D -> only A800 enqueued; IR_VALID stays 0 until the next word arrives; then IR=0x????A800 with IR_LEN32=1 (second halfword from the next word) and IR_PC=8000001A.
REQ-025 ID_TAKE held low -> IC_REQ stops with count=8; no enqueue overflow; after one take of a 16-bit instruction (count=7), no new fetch is issued; after a second take (count=6), a fetch resumes.
REQ-026 FLUSH while a fetch is in flight, with IC_A=...104 and FLUSH_PC target word ...200 -> IC_A stays ...104 until the ACK, that data is dropped, next IC_A=...200, and the queue contains no ...104 data.
